// File: rtl/seq111_rr_sched_if.sv
// Request/result bundle between serial requester channels and the shared "111" detector.
interface seq111_rr_sched_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]       req;
  logic [N_CH-1:0]       x_inp;
  logic [N_CH-1:0]       ch_clr;
  logic [N_CH-1:0]       gnt;
  logic                  y_valid;
  logic [CW-1:0]         y_ch;
  logic                  y_out;
  logic [N_CH*CNT_W-1:0] hit_cnt;

  modport master (
    output req, x_inp, ch_clr,
    input  gnt, y_valid, y_ch, y_out, hit_cnt
  );

  modport slave (
    input  req, x_inp, ch_clr,
    output gnt, y_valid, y_ch, y_out, hit_cnt
  );
endinterface

// File: rtl/seq111_rr_sched.sv
// Round-robin time-shared "111" Mealy detector with per-channel saved context.
// Optional per-channel saturating hit counters are enabled by `define SEQARB_HIT_CNT_EN.
module seq111_rr_sched #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  seq111_rr_sched_if.slave bus
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {C0 = 2'd0, C1 = 2'd1, C2 = 2'd2} ctx_t;

  // Returns {hit, next_context}; hits are non-overlapping.
  function automatic logic [2:0] step(input ctx_t cur, input logic x);
    if (!x) return {1'b0, C0};
    case (cur)
      C1:      return {1'b0, C2};
      C2:      return {1'b1, C0};
      default: return {1'b0, C1};
    endcase
  endfunction

  ctx_t          ctx [N_CH];
  logic [CW-1:0] ptr;
  logic [N_CH-1:0] gnt_c;
  logic [CW-1:0] sel;
  logic          any;
  logic [CW:0]   sum;
  logic [CW-1:0] idx;
  ctx_t          cur;
  logic [2:0]    step_r;
  logic [CW-1:0] ptr_nxt;

  logic          y_valid_p1;
  logic [CW-1:0] y_ch_p1;
  logic          y_out_p1;

  always_comb begin
    gnt_c = '0;
    sel   = '0;
    any   = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      sum = {1'b0, ptr} + (CW+1)'(k);
      if (sum >= (CW+1)'(N_CH)) sum = sum - (CW+1)'(N_CH);
      idx = sum[CW-1:0];
      if (!any && !rst && bus.req[idx]) begin
        any        = 1'b1;
        sel        = idx;
        gnt_c[idx] = 1'b1;
      end
    end
    // A clear arriving with the grant means the bit lands on a fresh context.
    cur     = bus.ch_clr[sel] ? C0 : ctx[sel];
    step_r  = step(cur, bus.x_inp[sel]);
    ptr_nxt = (sel == CW'(N_CH - 1)) ? '0 : sel + CW'(1);
  end

  assign bus.gnt = gnt_c;

  // Stage p1: registered result and context write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) ctx[i] <= C0;
      ptr        <= '0;
      y_valid_p1 <= 1'b0;
      y_ch_p1    <= '0;
      y_out_p1   <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (bus.ch_clr[i]) ctx[i] <= C0;
      end
      if (any) begin
        ctx[sel]   <= ctx_t'(step_r[1:0]);
        ptr        <= ptr_nxt;
        y_valid_p1 <= 1'b1;
        y_ch_p1    <= sel;
        y_out_p1   <= step_r[2];
      end else begin
        y_valid_p1 <= 1'b0;
        y_out_p1   <= 1'b0;
      end
    end
  end

  assign bus.y_valid = y_valid_p1;
  assign bus.y_ch    = y_ch_p1;
  assign bus.y_out   = y_out_p1;

`ifdef SEQARB_HIT_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt_p1 [N_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) cnt_p1[i] <= '0;
    end else if (any && step_r[2]) begin
      cnt_p1[sel] <= sat_inc(cnt_p1[sel]);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt
    assign bus.hit_cnt[g*CNT_W +: CNT_W] = cnt_p1[g];
  end
`else
  assign bus.hit_cnt = '0;
`endif
endmodule

// File: tb/tb_seq111_rr_sched.sv
// Bench for seq111_rr_sched: directed test-plan sequences plus random traffic vs a behavioural model.
module tb_seq111_rr_sched;
  localparam int N  = 4;
  localparam int CW = 2;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq111_rr_sched_if #(.N_CH(N), .CNT_W(CNT_W)) bus ();

  seq111_rr_sched #(.N_CH(N), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each channel tracks how many 1s are pending (0..2).
  int   ones [N];
  int   mptr;
  bit   m_vld;
  int   m_ch;
  bit   m_y;
  int   m_cnt [N];
  bit   started = 0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    if (rst) begin
      for (int i = 0; i < N; i++) begin ones[i] = 0; m_cnt[i] = 0; end
      mptr = 0; m_vld = 0; m_ch = 0; m_y = 0;
    end else begin
      for (int i = 0; i < N; i++) if (bus.ch_clr[i]) ones[i] = 0;
      g = pick(bus.req, mptr);
      if (g >= 0) begin
        m_y = 0;
        if (bus.x_inp[g]) begin
          ones[g] = ones[g] + 1;
          if (ones[g] == 3) begin m_y = 1; ones[g] = 0; end
        end else ones[g] = 0;
        m_vld = 1; m_ch = g; mptr = (g + 1) % N;
`ifdef SEQARB_HIT_CNT_EN
        if (m_y && m_cnt[g] < (1 << CNT_W) - 1) m_cnt[g] = m_cnt[g] + 1;
`endif
      end else begin
        m_vld = 0; m_y = 0;
      end
    end
    started = 1;
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    int g;
    logic [N-1:0] eg;
    if (started) begin
      g  = pick(bus.req, mptr);
      eg = (rst || g < 0) ? '0 : (N)'(1) << g;
      chk("gnt", int'(bus.gnt), int'(eg));
      chk("y_valid", int'(bus.y_valid), int'(m_vld));
      chk("y_ch", int'(bus.y_ch), m_ch);
      chk("y_out", int'(bus.y_out), int'(m_y));
      for (int i = 0; i < N; i++)
        chk("hit_cnt", int'(bus.hit_cnt[i*CNT_W +: CNT_W]), m_cnt[i]);
    end
  end

  logic [N-1:0] g_s;

  // Drive one cycle of inputs, capture the grant just before the edge, return after it.
  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] x, input logic [N-1:0] c);
    bus.req = r; bus.x_inp = x; bus.ch_clr = c;
    #3;
    g_s = bus.gnt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0; bus.x_inp = '0; bus.ch_clr = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [N-1:0] pend, px, clr;
  int hits;
  int ny [6];

  initial begin
    bus.req = '0; bus.x_inp = '0; bus.ch_clr = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_y_valid", int'(bus.y_valid), 0);
    chk("rst_y_ch", int'(bus.y_ch), 0);
    chk("rst_y_out", int'(bus.y_out), 0);
    chk("rst_hit_cnt", int'(bus.hit_cnt), 0);

    // Single channel: hits on results 3 and 6.
    for (int k = 0; k < 6; k++) begin
      drive(4'b0001, 4'b0001, 4'b0000);
      chk("sc_gnt", int'(g_s), 1);
      chk("sc_valid", int'(bus.y_valid), 1);
      chk("sc_ch", int'(bus.y_ch), 0);
      chk("sc_y", int'(bus.y_out), (k == 2 || k == 5) ? 1 : 0);
    end

    // Full load: rotating grant, hits only on results 9..12.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive(4'b1111, 4'b1111, 4'b0000);
      chk("fl_gnt", int'(g_s), 1 << (k % 4));
      chk("fl_ch", int'(bus.y_ch), k % 4);
      chk("fl_y", int'(bus.y_out), (k >= 8) ? 1 : 0);
    end

    // Context isolation.
    do_reset();
    hits = 0;
    drive(4'b0001, 4'b0001, 4'b0000); hits += int'(bus.y_out);
    drive(4'b0001, 4'b0001, 4'b0000); hits += int'(bus.y_out);
    drive(4'b0010, 4'b0010, 4'b0000); hits += int'(bus.y_out);
    drive(4'b0001, 4'b0001, 4'b0000); hits += int'(bus.y_out);
    chk("iso_last_y", int'(bus.y_out), 1);
    chk("iso_last_ch", int'(bus.y_ch), 0);
    chk("iso_hits", hits, 1);
    drive(4'b0010, 4'b0010, 4'b0000);
    drive(4'b0010, 4'b0010, 4'b0000);
    chk("iso_ch1_c1", int'(bus.y_out), 1);

    // Zero restart: 1,1,0,1,1,1 hits only on the 6th.
    do_reset();
    ny = '{1, 1, 0, 1, 1, 1};
    for (int k = 0; k < 6; k++) begin
      drive(4'b0001, ny[k] ? 4'b0001 : 4'b0000, 4'b0000);
      chk("zr_y", int'(bus.y_out), (k == 5) ? 1 : 0);
    end
`ifdef SEQARB_HIT_CNT_EN
    chk("zr_cnt", int'(bus.hit_cnt[CNT_W-1:0]), 1);
`else
    chk("zr_cnt", int'(bus.hit_cnt[CNT_W-1:0]), 0);
`endif

    // Clear collision.
    do_reset();
    drive(4'b0001, 4'b0001, 4'b0000);
    drive(4'b0001, 4'b0001, 4'b0000);
    drive(4'b0001, 4'b0001, 4'b0001);
    chk("cc_y", int'(bus.y_out), 0);
    drive(4'b0001, 4'b0001, 4'b0000);
    chk("cc_y2", int'(bus.y_out), 0);
    drive(4'b0001, 4'b0001, 4'b0000);
    chk("cc_y3", int'(bus.y_out), 1);

    // Reset mid-stream.
    do_reset();
    drive(4'b0100, 4'b0100, 4'b0000);
    drive(4'b0100, 4'b0100, 4'b0000);
    rst = 1'b1;
    drive(4'b0100, 4'b0100, 4'b0000);
    rst = 1'b0;
    chk("rm_gnt", int'(g_s), 0);
    chk("rm_valid", int'(bus.y_valid), 0);
    chk("rm_cnt", int'(bus.hit_cnt), 0);
    drive(4'b0100, 4'b0100, 4'b0000);
    chk("rm_y", int'(bus.y_out), 0);
    chk("rm_ch", int'(bus.y_ch), 2);

    // Random traffic with held requests, occasional clears and resets.
    pend = '0; px = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom % 3 != 0)) begin
          pend[i] = 1'b1;
          px[i]   = ($urandom % 4 != 0);
        end
        clr[i] = ($urandom % 12 == 0);
      end
      rst = ($urandom % 101 == 0);
      drive(pend, px, clr);
      pend = pend & ~g_s;
    end
    rst = 1'b0;
    drive('0, '0, '0);
    drive('0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
